clock_gen: RTL and testbench



---
 rtl/clock_gen.sv | 98 +++++++++
 tb/tb_clock_gen.sv | 129 ++++++++++++
 2 files changed

// File: rtl/clock_gen.sv
// Board-clock divider and core reset sequencer: clk = CLK / 2^DIV, resetn is held low after RST.
// Define CLOCK_GEN_RESET_STRETCH_EN to stretch resetn by RST_HOLD clk cycles; otherwise resetn follows ~RST on clk falls.
module clock_gen #(
  parameter int unsigned DIV      = 22,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic CLK,
  input  logic RST,
  output logic clk,
  output logic resetn
);

  // Single-cycle strobes marking the CLK edge where clk rises / falls.
  logic rise;
  logic fall;

  generate
    if (DIV == 0) begin : g_pass
      assign clk  = CLK;
      assign rise = 1'b1;
      assign fall = 1'b1;
    end else begin : g_div
      logic [DIV-1:0] cnt_q;
      logic [DIV-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign clk  = cnt_q[DIV-1];
      // MSB going 0->1 happens only at the half-period step; wrap to zero is the fall.
      assign rise = ~cnt_q[DIV-1] & cnt_d[DIV-1];
      assign fall = (cnt_d == '0);
    end
  endgenerate

  logic resetn_q;
  logic resetn_d;

`ifdef CLOCK_GEN_RESET_STRETCH_EN
  localparam logic [7:0] HOLD_MAX = RST_HOLD[7:0];

  logic [7:0] hold_q;
  logic [7:0] hold_d;

  // Release is judged on the post-increment count so that with DIV=0, where rise and
  // fall coincide, resetn still goes high after exactly RST_HOLD clk edges.
  always_comb begin
    hold_d   = hold_q;
    resetn_d = resetn_q;
    if (rise && (hold_q < HOLD_MAX)) begin
      hold_d = hold_q + 8'd1;
    end
    if (fall && (hold_d == HOLD_MAX)) begin
      resetn_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_q   <= '0;
      resetn_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      resetn_q <= resetn_d;
    end
  end
`else
  logic unused_rise;
  assign unused_rise = rise;

  always_comb begin
    resetn_d = resetn_q;
    if (fall) begin
      resetn_d = ~RST;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      resetn_q <= 1'b0;
    end else begin
      resetn_q <= resetn_d;
    end
  end
`endif

  assign resetn = resetn_q;

endmodule

// File: tb/tb_clock_gen.sv
// Directed bench for clock_gen: four instances (DIV = 0..3, RST_HOLD = 4) with independent resets.
// Expected clk/resetn are derived from the count of CLK edges since RST was released.
module tb_clock_gen;

`ifdef CLOCK_GEN_RESET_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif
  localparam int HOLD = 4;

  logic       CLK;
  logic       rst_i [4];
  wire  [3:0] clk_o;
  wire  [3:0] rstn_o;

  int n_checks;
  int n_fail;

  clock_gen #(.DIV(0), .RST_HOLD(HOLD)) u_div0 (.CLK(CLK), .RST(rst_i[0]), .clk(clk_o[0]), .resetn(rstn_o[0]));
  clock_gen #(.DIV(1), .RST_HOLD(HOLD)) u_div1 (.CLK(CLK), .RST(rst_i[1]), .clk(clk_o[1]), .resetn(rstn_o[1]));
  clock_gen #(.DIV(2), .RST_HOLD(HOLD)) u_div2 (.CLK(CLK), .RST(rst_i[2]), .clk(clk_o[2]), .resetn(rstn_o[2]));
  clock_gen #(.DIV(3), .RST_HOLD(HOLD)) u_div3 (.CLK(CLK), .RST(rst_i[3]), .clk(clk_o[3]), .resetn(rstn_o[3]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // k = number of CLK edges sampled with RST low; sampled just after a rising CLK edge.
  function automatic logic exp_clk(input int d, input int k);
    if (d == 0) return 1'b1;
    return logic'(((k % (1 << d)) >> (d - 1)) & 1);
  endfunction

  function automatic logic exp_rstn(input int d, input int k);
    if (STRETCH) return (k >= HOLD * (1 << d));
    return (k >= (1 << d));
  endfunction

  // Run nk edges after release on instance d; resetn is compared only from edge lo onward.
  task automatic run_seq(input int d, input int nk, input int lo);
    for (int k = 1; k <= nk; k++) begin
      tick();
      check($sformatf("div%0d_clk_k%0d", d, k), {31'd0, clk_o[d]}, {31'd0, exp_clk(d, k)});
      if (k >= lo)
        check($sformatf("div%0d_rstn_k%0d", d, k), {31'd0, rstn_o[d]}, {31'd0, exp_rstn(d, k)});
    end
  endtask

  task automatic pulse_rst(input int d);
    rst_i[d] = 1'b1;
    tick();
    check($sformatf("div%0d_pulse_clk", d), {31'd0, clk_o[d]}, 32'd0);
`ifdef CLOCK_GEN_RESET_STRETCH_EN
    check($sformatf("div%0d_pulse_rstn", d), {31'd0, rstn_o[d]}, 32'd0);
`endif
    rst_i[d] = 1'b0;
  endtask

  initial begin
    int lo2;
    n_checks = 0;
    n_fail   = 0;
    lo2      = STRETCH ? 1 : 4;
    for (int i = 0; i < 4; i++) rst_i[i] = 1'b1;

    // Reset state on every instance.
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 1; i < 4; i++)
        check($sformatf("rst_clk_div%0d", i), {31'd0, clk_o[i]}, 32'd0);
      for (int i = 0; i < 4; i++)
        check($sformatf("rst_rstn_div%0d", i), {31'd0, rstn_o[i]}, 32'd0);
    end

    // DIV=1: clk toggles each edge, resetn released after 8 (stretch) or 2 edges.
    rst_i[1] = 1'b0;
    run_seq(1, 12, 1);

    // DIV=0: clk is CLK itself.
    rst_i[0] = 1'b0;
    run_seq(0, 8, 1);
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      #1;
      check("div0_clk_low_phase", {31'd0, clk_o[0]}, 32'd0);
    end

    // DIV=3: free run, period 8 with 4 high / 4 low.
    rst_i[3] = 1'b0;
    run_seq(3, 64, 1);

    // DIV=2: run past release, then a one-cycle pulse while clk=1 and resetn=1.
    rst_i[2] = 1'b0;
    run_seq(2, 18, 1);
    check("div2_pre_pulse_clk", {31'd0, clk_o[2]}, 32'd1);
    check("div2_pre_pulse_rstn", {31'd0, rstn_o[2]}, 32'd1);
    pulse_rst(2);
    run_seq(2, 18, lo2);

    // DIV=2: reassert when hold has reached 2; the full hold must restart.
    pulse_rst(2);
    run_seq(2, 7, lo2);
    pulse_rst(2);
    run_seq(2, 18, lo2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule
